// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store.
// One transaction in flight; the response goes back to whoever owns it.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int MAX_STARVE = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                lsu_req_valid,
  input  logic                lsu_req_wr,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_req_ready,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_wr,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  localparam logic [3:0] MAX_S = 4'(MAX_STARVE);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       owner_lsu;
  logic       kill;
  logic       arb_ok;
  logic       if_win;
  logic       if_grant;
  logic       lsu_grant;

  // Grant is purely combinational and only offered in IDLE.
  always_comb begin
    arb_ok    = !reset && (state == IDLE);
    if_win    = if_req_valid &&
                (!lsu_req_valid || (starve_cnt == MAX_S));
    if_grant  = arb_ok && if_win;
    lsu_grant = arb_ok && lsu_req_valid && !if_win;
    if_req_ready  = if_grant;
    lsu_req_ready = lsu_grant;
  end

  // Transaction FSM with registered memory request and response outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      owner_lsu     <= 1'b0;
      kill          <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_wr    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      if_rsp_valid  <= 1'b0;
      if_rsp_data   <= '0;
      lsu_rsp_valid <= 1'b0;
      lsu_rsp_data  <= '0;
    end else begin
      if_rsp_valid  <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          kill <= 1'b0;
          if (if_grant) begin
            state         <= ISSUE;
            owner_lsu     <= 1'b0;
            kill          <= flush;
            starve_cnt    <= '0;
            mem_req_valid <= 1'b1;
            mem_req_wr    <= 1'b0;
            mem_req_addr  <= if_req_addr;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
          end else if (lsu_grant) begin
            state         <= ISSUE;
            owner_lsu     <= 1'b1;
            mem_req_valid <= 1'b1;
            mem_req_wr    <= lsu_req_wr;
            mem_req_addr  <= lsu_req_addr;
            mem_req_wdata <= lsu_req_wdata;
            mem_req_wmask <= lsu_req_wr ? lsu_req_wmask : '0;
            if (if_req_valid && (starve_cnt != MAX_S))
              starve_cnt <= starve_cnt + 4'd1;
          end
        end
        ISSUE: begin
          if (flush && !owner_lsu)
            kill <= 1'b1;
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (flush && !owner_lsu)
            kill <= 1'b1;
          if (mem_rsp_valid) begin
            state <= IDLE;
            if (owner_lsu) begin
              lsu_rsp_valid <= 1'b1;
              lsu_rsp_data  <= mem_req_wr ? '0 : mem_rsp_data;
            end else if (!kill && !flush) begin
              if_rsp_valid <= 1'b1;
              if_rsp_data  <= mem_rsp_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency,
// flush kill, reset abandon and stray responses.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        if_req_valid = 1'b0;
  logic [31:0] if_req_addr = '0;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [63:0] if_rsp_data;
  logic        lsu_req_valid = 1'b0;
  logic        lsu_req_wr = 1'b0;
  logic [31:0] lsu_req_addr = '0;
  logic [63:0] lsu_req_wdata = '0;
  logic [7:0]  lsu_req_wmask = '0;
  logic        lsu_req_ready;
  logic        lsu_rsp_valid;
  logic [63:0] lsu_rsp_data;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_wr;
  logic [31:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rsp_data = '0;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(64), .MAX_STARVE(4)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr),
    .if_req_ready(if_req_ready), .if_rsp_valid(if_rsp_valid),
    .if_rsp_data(if_rsp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_wr(lsu_req_wr),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata),
    .lsu_req_wmask(lsu_req_wmask), .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wr(mem_req_wr), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  // IF transaction with zero-wait memory; optional flush points.
  task automatic do_if(input logic [31:0] a, input logic [63:0] d,
                       input logic fl_idle, input logic fl_rsp,
                       input logic exp_pulse, input logic [63:0] exp_d);
    if_req_valid = 1'b1;
    if_req_addr  = a;
    flush        = fl_idle;
    mem_req_ready = 1'b1;
    @(negedge clock);
    check("txn_if_ready", 64'(if_req_ready), 64'd1);
    nxt();
    if_req_valid = 1'b0;
    flush = 1'b0;
    nxt();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = d;
    flush = fl_rsp;
    nxt();
    mem_rsp_valid = 1'b0;
    flush = 1'b0;
    mem_req_ready = 1'b0;
    @(negedge clock);
    check("txn_if_pulse", 64'(if_rsp_valid), 64'(exp_pulse));
    check("txn_if_data", if_rsp_data, exp_d);
    nxt();
  endtask

  initial begin
    int g;
    int cyc;
    logic [1:0] exp_g;
    nxt();
    nxt();
    reset = 1'b0;
    @(negedge clock);
    check("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    check("rst_rdy", {62'd0, if_req_ready, lsu_req_ready}, 64'd0);
    check("rst_rsp", {62'd0, if_rsp_valid, lsu_rsp_valid}, 64'd0);
    check("rst_addr", 64'(mem_req_addr), 64'd0);
    check("rst_fields", {mem_req_wdata}, 64'd0);
    nxt();

    // IF only, memory ready immediately
    if_req_valid = 1'b1;
    if_req_addr  = 32'h8000_0000;
    mem_req_ready = 1'b1;
    @(negedge clock);
    check("if_ready_T", 64'(if_req_ready), 64'd1);
    check("if_lsu_ready_T", 64'(lsu_req_ready), 64'd0);
    check("if_memv_T", 64'(mem_req_valid), 64'd0);
    nxt();
    if_req_valid = 1'b0;
    @(negedge clock);
    check("if_memv_T1", 64'(mem_req_valid), 64'd1);
    check("if_addr_T1", 64'(mem_req_addr), 64'h8000_0000);
    check("if_wmask_T1", 64'(mem_req_wmask), 64'd0);
    check("if_wr_T1", 64'(mem_req_wr), 64'd0);
    nxt();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h00000013_00000093;
    @(negedge clock);
    check("if_memv_T2", 64'(mem_req_valid), 64'd0);
    check("if_rspv_T2", 64'(if_rsp_valid), 64'd0);
    nxt();
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    @(negedge clock);
    check("if_rspv_T3", 64'(if_rsp_valid), 64'd1);
    check("if_rspd_T3", if_rsp_data, 64'h00000013_00000093);
    check("if_lsu_rspv_T3", 64'(lsu_rsp_valid), 64'd0);
    nxt();
    @(negedge clock);
    check("if_rspv_T4", 64'(if_rsp_valid), 64'd0);
    check("if_rspd_hold", if_rsp_data, 64'h00000013_00000093);
    nxt();

    // LSU store with a 3-cycle memory stall
    lsu_req_valid = 1'b1;
    lsu_req_wr    = 1'b1;
    lsu_req_addr  = 32'h8000_1000;
    lsu_req_wdata = 64'hDEADBEEF;
    lsu_req_wmask = 8'h0F;
    @(negedge clock);
    check("st_ready", 64'(lsu_req_ready), 64'd1);
    nxt();
    lsu_req_valid = 1'b0;
    lsu_req_wdata = '0;
    lsu_req_addr  = '0;
    lsu_req_wmask = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("st_stall_v", 64'(mem_req_valid), 64'd1);
      check("st_stall_a", 64'(mem_req_addr), 64'h8000_1000);
      check("st_stall_d", mem_req_wdata, 64'hDEADBEEF);
      check("st_stall_m", {55'd0, mem_req_wr, mem_req_wmask},
            {55'd0, 1'b1, 8'h0F});
      nxt();
    end
    mem_req_ready = 1'b1;
    @(negedge clock);
    check("st_issue_v", 64'(mem_req_valid), 64'd1);
    nxt();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h1234_5678;
    @(negedge clock);
    check("st_wait_v", 64'(mem_req_valid), 64'd0);
    nxt();
    mem_rsp_valid = 1'b0;
    @(negedge clock);
    check("st_rspv", 64'(lsu_rsp_valid), 64'd1);
    check("st_rspd", lsu_rsp_data, 64'd0);
    check("st_if_rspv", 64'(if_rsp_valid), 64'd0);
    nxt();
    @(negedge clock);
    check("st_rspv_end", 64'(lsu_rsp_valid), 64'd0);
    nxt();

    // Contention: expect L,L,L,L,I,L,L,L,L,I
    if_req_valid  = 1'b1;
    if_req_addr   = 32'h8000_0100;
    lsu_req_valid = 1'b1;
    lsu_req_wr    = 1'b0;
    lsu_req_addr  = 32'h8000_2000;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h1111;
    g = 0;
    cyc = 0;
    while (g < 11 && cyc < 80) begin
      @(negedge clock);
      if (if_req_ready || lsu_req_ready) begin
        exp_g = (g == 4 || g == 9) ? 2'b10 : 2'b01;
        check("cont_grant", {62'd0, if_req_ready, lsu_req_ready},
              {62'd0, exp_g});
        g++;
      end
      cyc++;
      nxt();
      if (g == 11) begin
        if_req_valid  = 1'b0;
        lsu_req_valid = 1'b0;
      end
    end
    check("cont_count", 64'(g), 64'd11);
    if_req_valid  = 1'b0;
    lsu_req_valid = 1'b0;
    repeat (4) nxt();
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    nxt();

    // Flush in WAIT before the response
    if_req_valid  = 1'b1;
    if_req_addr   = 32'h8000_0000;
    mem_req_ready = 1'b1;
    @(negedge clock);
    check("fl_ready", 64'(if_req_ready), 64'd1);
    nxt();
    if_req_valid = 1'b0;
    nxt();
    flush = 1'b1;
    nxt();
    flush = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'hBAD;
    nxt();
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    @(negedge clock);
    check("fl_no_pulse", 64'(if_rsp_valid), 64'd0);
    check("fl_data_hold", if_rsp_data, 64'h1111);
    nxt();
    do_if(32'h8000_0004, 64'h2222, 1'b0, 1'b0, 1'b1, 64'h2222);
    do_if(32'h8000_0008, 64'h3333, 1'b1, 1'b0, 1'b0, 64'h2222);
    do_if(32'h8000_000C, 64'h4444, 1'b0, 1'b1, 1'b0, 64'h2222);

    // Reset while ISSUE is stalled
    lsu_req_valid = 1'b1;
    lsu_req_wr    = 1'b0;
    lsu_req_addr  = 32'h0000_0100;
    @(negedge clock);
    check("rs_ready", 64'(lsu_req_ready), 64'd1);
    nxt();
    lsu_req_valid = 1'b0;
    @(negedge clock);
    check("rs_issue_v", 64'(mem_req_valid), 64'd1);
    nxt();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    @(negedge clock);
    check("rs_memv", 64'(mem_req_valid), 64'd0);
    check("rs_addr", 64'(mem_req_addr), 64'd0);
    check("rs_ifd", if_rsp_data, 64'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h5555;
    nxt();
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("rs_no_pulse", {62'd0, if_rsp_valid, lsu_rsp_valid}, 64'd0);
      nxt();
    end

    // Stray response in IDLE
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h6666;
    nxt();
    mem_rsp_valid = 1'b0;
    @(negedge clock);
    check("stray_no_pulse", {62'd0, if_rsp_valid, lsu_rsp_valid}, 64'd0);
    check("stray_memv", 64'(mem_req_valid), 64'd0);
    nxt();
    if_req_valid = 1'b1;
    if_req_addr  = 32'h8000_0020;
    @(negedge clock);
    check("stray_idle", 64'(if_req_ready), 64'd1);
    nxt();
    if_req_valid = 1'b0;
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
